rgb_sequencer: RTL

Keyframe colour sequencer for the on-board RGB LED. Holds a small programmable table of colour keyframes, steps through it with linear per-channel fades and per-key hold times, and emits three 8-bit PWM streams that connect directly to the RGB0/1/2 PWM inputs of the SB_RGBA_DRV primitive. It replaces a fixed-pattern LED driver: software or another block loads keyframes, and this block schedules the LED.

---
 rtl/rgb_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rgb_sequencer.sv
// rgb_sequencer: programmable keyframe table, linear per-channel fades and hold times, three 8-bit PWM outputs.
// Latency: a new duty is compared on the next cycle and r/g/b are registered, so pwm_cnt to output is 1 cycle.
// Backpressure: none; table writes are accepted in any state, and run=0 stops playback on the next edge.
module rgb_sequencer #(
  parameter int CLK_DIV = 48000,
  parameter int N_KEYS  = 8,
  localparam int AW = $clog2(N_KEYS),
  localparam int PW = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] last_key,
  input  logic          run,
  output logic          busy,
  output logic [AW-1:0] key_idx,
  output logic [7:0]    duty_r,
  output logic [7:0]    duty_g,
  output logic [7:0]    duty_b,
  output logic          r,
  output logic          g,
  output logic          b
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FADE = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] key_idx_q, key_idx_d;
  logic [7:0]    tgt_r_q, tgt_r_d, tgt_g_q, tgt_g_d, tgt_b_q, tgt_b_d;
  logic [7:0]    hold_cnt_q, hold_cnt_d;
  logic [7:0]    duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_cnt_q;
  logic          r_q, g_q, b_q;
  logic [31:0]   table_q [N_KEYS];

  logic tick;
  logic all_eq;

  // Move one step toward the target; never overshoots, so no wrap is possible.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  assign tick   = ((state_q == S_FADE) || (state_q == S_HOLD)) && (presc_q == PW'(CLK_DIV - 1));
  assign all_eq = (duty_r_q == tgt_r_q) && (duty_g_q == tgt_g_q) && (duty_b_q == tgt_b_q);

  // Keyframe table: single-cycle writes; LOAD sees the pre-write value on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  // Next-state, fade stepping, hold countdown and prescaler; run=0 overrides everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    key_idx_d  = key_idx_q;
    tgt_r_d    = tgt_r_q;
    tgt_g_d    = tgt_g_q;
    tgt_b_d    = tgt_b_q;
    hold_cnt_d = hold_cnt_q;
    duty_r_d   = duty_r_q;
    duty_g_d   = duty_g_q;
    duty_b_d   = duty_b_q;
    presc_d    = '0;
    if ((state_q != S_IDLE) && !run) begin
      state_d   = S_IDLE;
      key_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          key_idx_d = '0;
          if (run) state_d = S_LOAD;
        end
        S_LOAD: begin
          {hold_cnt_d, tgt_b_d, tgt_g_d, tgt_r_d} = table_q[key_idx_q];
          state_d = S_FADE;
        end
        S_FADE: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (all_eq) begin
            state_d = S_HOLD;
          end else if (tick) begin
            duty_r_d = step_toward(duty_r_q, tgt_r_q);
            duty_g_d = step_toward(duty_g_q, tgt_g_q);
            duty_b_d = step_toward(duty_b_q, tgt_b_q);
          end
        end
        S_HOLD: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (hold_cnt_q == 8'd0) begin
              key_idx_d = (key_idx_q >= last_key) ? '0 : key_idx_q + AW'(1);
              state_d   = S_LOAD;
            end else begin
              hold_cnt_d = hold_cnt_q - 8'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_idx_q  <= '0;
      tgt_r_q    <= '0;
      tgt_g_q    <= '0;
      tgt_b_q    <= '0;
      hold_cnt_q <= '0;
      duty_r_q   <= '0;
      duty_g_q   <= '0;
      duty_b_q   <= '0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      key_idx_q  <= key_idx_d;
      tgt_r_q    <= tgt_r_d;
      tgt_g_q    <= tgt_g_d;
      tgt_b_q    <= tgt_b_d;
      hold_cnt_q <= hold_cnt_d;
      duty_r_q   <= duty_r_d;
      duty_g_q   <= duty_g_d;
      duty_b_q   <= duty_b_d;
      presc_q    <= presc_d;
    end
  end

  // Free-running PWM counter and registered compare outputs, independent of the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      r_q       <= 1'b0;
      g_q       <= 1'b0;
      b_q       <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      r_q       <= (pwm_cnt_q < duty_r_q);
      g_q       <= (pwm_cnt_q < duty_g_q);
      b_q       <= (pwm_cnt_q < duty_b_q);
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign key_idx = key_idx_q;
  assign duty_r  = duty_r_q;
  assign duty_g  = duty_g_q;
  assign duty_b  = duty_b_q;
  assign r       = r_q;
  assign g       = g_q;
  assign b       = b_q;

endmodule
